// File: rtl/bcd2bin.sv
// -----------------------------------------------------------------------------
// bcd2bin
//   Signed packed-BCD to two's-complement binary converter (inverse of bin2bcd).
//   Fully pipelined: one BCD digit is folded into the magnitude per stage, so a
//   new word can be accepted every clock. Latency is DIGITS clock edges from the
//   edge that samples bcd_vld to the edge that raises bin_vld.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active high; flushes every word in flight
//   bcd      {sign, digit[DIGITS-1] (MS) .. digit[0] (units)}, sign 1 = negative
//   bcd_vld  input word valid, sampled every rising edge, no backpressure
//   bin      converted BIN_W-bit two's-complement result, registered
//   bin_vld  one-cycle pulse per accepted word
//   bin_err  qualifies bin_vld: illegal digit or value out of range (bin = 0)
// -----------------------------------------------------------------------------
module bcd2bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*DIGITS:0] bcd,
  input  logic              bcd_vld,
  output logic [BIN_W-1:0]  bin,
  output logic              bin_vld,
  output logic              bin_err
);

  localparam int DW    = 4 * DIGITS;
  localparam int ACC_W = $clog2(10 ** DIGITS);

  // Range limits of the magnitude; negative side allows one extra count.
  localparam logic [31:0] POS_MAX = 32'((64'd1 << (BIN_W - 1)) - 64'd1);
  localparam logic [31:0] NEG_MAX = 32'(64'd1 << (BIN_W - 1));

  // acc*10 + d using shifts and adds only. Illegal digits may wrap the
  // accumulator, which is harmless because such words are already flagged.
  function automatic logic [ACC_W-1:0] mac10(input logic [ACC_W-1:0] acc,
                                             input logic [3:0]       d);
    return (acc << 3) + (acc << 1) + ACC_W'(d);
  endfunction

  // Per-stage pipeline state. rem[k] holds the digits not yet consumed,
  // left-aligned, so the next digit to fold in is always the top nibble.
  logic             vld [1:DIGITS];
  logic             sgn [1:DIGITS];
  logic             err [1:DIGITS];
  logic [ACC_W-1:0] acc [1:DIGITS];
  logic [DW-1:0]    rem [1:DIGITS];

  logic [3:0] in_digit;
  assign in_digit = bcd[DW-1 -: 4];

  // Digit stages. Valid bits shift every cycle; data registers only load
  // behind a valid bit, so bubbles travel through unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DIGITS; k++) begin
        vld[k] <= 1'b0;
        sgn[k] <= 1'b0;
        err[k] <= 1'b0;
        acc[k] <= '0;
        rem[k] <= '0;
      end
    end else begin
      vld[1] <= bcd_vld;
      if (bcd_vld) begin
        sgn[1] <= bcd[DW];
        err[1] <= (in_digit > 4'd9);
        acc[1] <= mac10('0, in_digit);
        rem[1] <= bcd[DW-1:0] << 4;
      end
      for (int k = 2; k <= DIGITS; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          sgn[k] <= sgn[k-1];
          err[k] <= err[k-1] | (rem[k-1][DW-1 -: 4] > 4'd9);
          acc[k] <= mac10(acc[k-1], rem[k-1][DW-1 -: 4]);
          rem[k] <= rem[k-1] << 4;
        end
      end
    end
  end

  // Final range check and negation feeding the output register.
  logic [31:0]      mag_ext;
  logic [BIN_W-1:0] mag_t;
  logic             range_err;
  logic             out_err;
  logic [BIN_W-1:0] out_val;

  always_comb begin
    mag_ext   = 32'(acc[DIGITS]);
    mag_t     = mag_ext[BIN_W-1:0];
    range_err = sgn[DIGITS] ? (mag_ext > NEG_MAX) : (mag_ext > POS_MAX);
    out_err   = err[DIGITS] | range_err;
    out_val   = '0;
    if (!out_err) begin
      // Negative zero negates to zero; -2^(BIN_W-1) negates onto itself.
      out_val = sgn[DIGITS] ? (~mag_t + 1'b1) : mag_t;
    end
  end

  // Output register: bin and bin_err hold while no result is emerging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin     <= '0;
      bin_vld <= 1'b0;
      bin_err <= 1'b0;
    end else begin
      bin_vld <= vld[DIGITS];
      if (vld[DIGITS]) begin
        bin     <= out_val;
        bin_err <= out_err;
      end
    end
  end

endmodule
